// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch handshake between the fetch stage (master) and
// instruction memory (slave).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// selects the next PC on retire. Optional fetch watchdog via FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         instr_pc,
    output logic [31:0]         pc_plus4,
    input  logic                ex_done,
    input  logic                jump,
    input  logic                j_reg,
    input  logic                branch_eq,
    input  logic                branch_not_eq,
    input  logic                alu_zero,
    input  logic [31:0]         rs_data,
    output logic [31:0]         retired_count,
    output logic                fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;
    logic        take_branch;
    logic        timeout_hit;

    assign pc_plus4       = instr_pc + 32'd4;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = (state == FETCH) && !reset;

    // jr outranks jump, which outranks a taken conditional branch
    always_comb begin
        branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        take_branch   = (branch_eq & alu_zero) | (branch_not_eq & ~alu_zero);
        next_pc       = pc_plus4;
        if (j_reg) begin
            next_pc = rs_data & 32'hFFFF_FFFC;
        end else if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem.imem_ready) begin
                    state_next = VALID;
                end else if (timeout_hit) begin
                    state_next = HALT;
                end
            end
            VALID: begin
                if (ex_done) begin
                    state_next = FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= RESET_PC;
            instr         <= 32'd0;
            instr_valid   <= 1'b0;
            instr_pc      <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        instr       <= imem.imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (ex_done) begin
                        pc            <= next_pc;
                        instr_valid   <= 1'b0;
                        retired_count <= retired_count + 32'd1;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] watchdog;

    assign timeout_hit = (state == FETCH) && !imem.imem_ready
                         && (watchdog == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts every time a fresh fetch begins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            watchdog  <= 32'd0;
            fetch_err <= 1'b0;
        end else if (state == FETCH) begin
            if (imem.imem_ready) begin
                watchdog <= 32'd0;
            end else begin
                watchdog <= watchdog + 32'd1;
            end
            if (timeout_hit) begin
                fetch_err <= 1'b1;
            end
        end else if ((state == VALID) && ex_done) begin
            watchdog <= 32'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven control-flow vectors,
// hand-written reset/stall sequences and randomized instructions vs a PC model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        ex_done;
    logic        jump;
    logic        j_reg;
    logic        branch_eq;
    logic        branch_not_eq;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic [31:0] retired_count;
    logic        fetch_err;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .ex_done       (ex_done),
        .jump          (jump),
        .j_reg         (j_reg),
        .branch_eq     (branch_eq),
        .branch_not_eq (branch_not_eq),
        .alu_zero      (alu_zero),
        .rs_data       (rs_data),
        .retired_count (retired_count),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_pc;
    logic [31:0] model_count;
    logic [31:0] model_instr;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr_word;
        logic        jmp;
        logic        jr;
        logic        beq;
        logic        bne;
        logic        zero;
        logic [31:0] rs;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Next-PC rules written with plain arithmetic on addresses
    function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] iw,
                                                input logic jmp, input logic jr,
                                                input logic beq, input logic bne,
                                                input logic zero, input logic [31:0] rs);
        logic [31:0]        link;
        logic signed [15:0] imm;
        int                 off;
        link = pc + 32'd4;
        imm  = iw[15:0];
        off  = int'(imm) * 4;
        if (jr) return rs - (rs % 32'd4);
        if (jmp) return (link / 32'h1000_0000) * 32'h1000_0000 + (iw % 32'h0400_0000) * 32'd4;
        if ((beq && zero) || (bne && !zero)) return link + 32'(off);
        return link;
    endfunction

    task automatic idle_inputs();
        ex_done                = 1'b0;
        jump                   = 1'b0;
        j_reg                  = 1'b0;
        branch_eq              = 1'b0;
        branch_not_eq          = 1'b0;
        alu_zero               = 1'b0;
        rs_data                = 32'd0;
        imem_bus.imem_ready    = 1'b0;
        imem_bus.imem_rdata    = 32'd0;
    endtask

    task automatic randomize_controls();
        jump          = 1'($urandom);
        j_reg         = 1'($urandom);
        branch_eq     = 1'($urandom);
        branch_not_eq = 1'($urandom);
        alu_zero      = 1'($urandom);
        rs_data       = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        #1;
        check_output("req_low_in_reset", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        model_pc    = RESET_PC;
        model_count = 32'd0;
        #1;
        check_output("reset_req", 32'(imem_bus.imem_req), 32'd1);
        check_output("reset_addr", imem_bus.imem_addr, RESET_PC);
        check_output("reset_count", retired_count, 32'd0);
        check_output("reset_valid", 32'(instr_valid), 32'd0);
    endtask

    // Drive inputs for the next rising edge while in FETCH; stalls 'delay' cycles
    task automatic apply_stimulus(input logic [31:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            check_output("fetch_req", 32'(imem_bus.imem_req), 32'd1);
            check_output("fetch_addr_stable", imem_bus.imem_addr, model_pc);
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rdata = $urandom;
            ex_done             = 1'($urandom);
            randomize_controls();
            @(negedge clk);
            check_output("count_in_fetch", retired_count, model_count);
            check_output("valid_in_fetch", 32'(instr_valid), 32'd0);
        end
        idle_inputs();
        check_output("fetch_addr", imem_bus.imem_addr, model_pc);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = data;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = $urandom;
        model_instr         = data;
        check_output("instr_valid", 32'(instr_valid), 32'd1);
        check_output("instr", instr, data);
        check_output("instr_pc", instr_pc, model_pc);
        check_output("pc_plus4", pc_plus4, model_pc + 32'd4);
        check_output("req_in_valid", 32'(imem_bus.imem_req), 32'd0);
    endtask

    task automatic retire(input logic jmp, input logic jr, input logic beq, input logic bne,
                          input logic zero, input logic [31:0] rs,
                          input logic [31:0] exp_next, input int hold);
        for (int i = 0; i < hold; i++) begin
            imem_bus.imem_ready = 1'b1;
            imem_bus.imem_rdata = $urandom;
            ex_done             = 1'b0;
            randomize_controls();
            @(negedge clk);
            check_output("valid_held", 32'(instr_valid), 32'd1);
            check_output("instr_held", instr, model_instr);
        end
        imem_bus.imem_ready = 1'b0;
        ex_done             = 1'b1;
        jump                = jmp;
        j_reg               = jr;
        branch_eq           = beq;
        branch_not_eq       = bne;
        alu_zero            = zero;
        rs_data             = rs;
        @(negedge clk);
        idle_inputs();
        model_pc    = exp_next;
        model_count = model_count + 32'd1;
        check_output("valid_after_retire", 32'(instr_valid), 32'd0);
        check_output("req_after_retire", 32'(imem_bus.imem_req), 32'd1);
        check_output("next_addr", imem_bus.imem_addr, model_pc);
        check_output("retired_count", retired_count, model_count);
    endtask

    task automatic goto_pc(input logic [31:0] target);
        apply_stimulus($urandom, 0);
        retire(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, target, target, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin
        logic [31:0] iw;
        logic        c_j, c_jr, c_beq, c_bne, c_z;
        logic [31:0] c_rs;

        vecs[0] = '{"beq_taken",     32'h0000_0008, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0004};
        vecs[1] = '{"beq_not_taken", 32'h0000_0008, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_000C};
        vecs[2] = '{"bne_taken",     32'h0000_0008, 32'h1400_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0018};
        vecs[3] = '{"jal",           32'h1000_0010, 32'h0C00_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000_0100};
        vecs[4] = '{"jr_over_jump",  32'h0000_0080, 32'h0800_1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 32'h0000_0200};
        vecs[5] = '{"pc_wrap",       32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[6] = '{"bne_not_taken", 32'h0000_0100, 32'h1400_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0104};
        vecs[7] = '{"beq_min_imm",   32'h0000_0200, 32'h1000_8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFE_0204};
        vecs[8] = '{"jump_region",   32'h2FFF_FFFC, 32'h0800_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3000_000C};

        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);

        // First fetch answered in the same cycle reset is released
        do_reset();
        apply_stimulus(32'h2008_0005, 0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 0);

        // Sequential retires with a 3-cycle memory stall
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus($urandom, 3);
            retire(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, model_pc + 32'd4, 1);
        end
        check_output("seq_addr", imem_bus.imem_addr, 32'h0000_000C);
        check_output("seq_count", retired_count, 32'd3);

        for (int v = 0; v < 9; v++) begin
            goto_pc(vecs[v].pc);
            apply_stimulus(vecs[v].instr_word, 1);
            retire(vecs[v].jmp, vecs[v].jr, vecs[v].beq, vecs[v].bne, vecs[v].zero,
                   vecs[v].rs, vecs[v].exp_next, 0);
            check_output(vecs[v].name, imem_bus.imem_addr, vecs[v].exp_next);
        end

        // Async reset while an instruction is held in VALID at PC 0x40
        goto_pc(32'h0000_0040);
        apply_stimulus(32'h1234_5678, 0);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        check_output("midreset_valid", 32'(instr_valid), 32'd0);
        check_output("midreset_req", 32'(imem_bus.imem_req), 32'd0);
        @(negedge clk);
        check_output("midreset_instr", instr, 32'd0);
        check_output("midreset_instr_pc", instr_pc, 32'd0);
        imem_bus.imem_ready = 1'b0;
        reset       = 1'b0;
        model_pc    = RESET_PC;
        model_count = 32'd0;
        #1;
        check_output("midreset_addr", imem_bus.imem_addr, RESET_PC);
        check_output("midreset_count", retired_count, 32'd0);
        check_output("midreset_req_after", 32'(imem_bus.imem_req), 32'd1);

        // Randomized instruction stream against the next-PC model
        for (int n = 0; n < 40; n++) begin
            iw    = $urandom;
            c_j   = ($urandom_range(0, 3) == 0);
            c_jr  = ($urandom_range(0, 5) == 0);
            c_beq = 1'($urandom);
            c_bne = 1'($urandom);
            c_z   = 1'($urandom);
            c_rs  = $urandom;
            apply_stimulus(iw, $urandom_range(0, 3));
            retire(c_j, c_jr, c_beq, c_bne, c_z, c_rs,
                   ref_next_pc(model_pc, iw, c_j, c_jr, c_beq, c_bne, c_z, c_rs),
                   $urandom_range(0, 2));
        end

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            imem_bus.imem_ready = 1'b0;
            @(negedge clk);
            check_output("fetch_err_timing", 32'(fetch_err), (k >= TIMEOUT) ? 32'd1 : 32'd0);
        end
        check_output("halt_req", 32'(imem_bus.imem_req), 32'd0);
        check_output("halt_valid", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            ex_done             = 1'b1;
            imem_bus.imem_ready = 1'b1;
            randomize_controls();
            @(negedge clk);
            check_output("halt_addr", imem_bus.imem_addr, model_pc);
            check_output("halt_count", retired_count, 32'd0);
            check_output("halt_err_sticky", 32'(fetch_err), 32'd1);
            check_output("halt_valid_held", 32'(instr_valid), 32'd0);
        end
        do_reset();
        check_output("err_cleared", 32'(fetch_err), 32'd0);
`else
        do_reset();
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            imem_bus.imem_ready = 1'b0;
            @(negedge clk);
        end
        check_output("no_watchdog_err", 32'(fetch_err), 32'd0);
        check_output("no_watchdog_req", 32'(imem_bus.imem_req), 32'd1);
        apply_stimulus(32'h0000_0000, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
